// File: rtl/sat_fifo_pkg.sv
// Constants and types shared by the FIFO tree: word width, buffer geometry,
// and the source encoding used by merge nodes.
package sat_fifo_pkg;

    localparam int DATA_WIDTH  = 36;
    localparam int FIFO_DEPTH  = 16;
    localparam int FIFO_ADDR_W = $clog2(FIFO_DEPTH);

    typedef enum logic {
        SRC_A = 1'b0,
        SRC_B = 1'b1
    } src_e;

    function automatic src_e gnt_to_src(input logic [1:0] gnt);
        return gnt[1] ? SRC_B : SRC_A;
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin arbiter: a lone request wins outright, a tie goes to
// the input that did not win last time.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = req;
        if (&req)
            gnt = last_grant ? 2'b01 : 2'b10;
    end

endmodule

// File: rtl/fifo_merge_node.sv
// Two-to-one FIFO tree merge node: round-robin reads from two upstream buffers,
// one-entry skid absorbs the read latency when the downstream buffer fills.
module fifo_merge_node
    import sat_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = sat_fifo_pkg::DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] a_data_i,
    input  logic                  a_empty_i,
    output logic                  a_rden_o,
    input  logic [DATA_WIDTH-1:0] b_data_i,
    input  logic                  b_empty_i,
    output logic                  b_rden_o,
    output logic [DATA_WIDTH-1:0] out_data_o,
    output logic                  out_wren_o,
    input  logic                  out_full_i
);

    logic                  pending;
    src_e                  pend_src;
    src_e                  last_grant;
    logic                  skid_valid;
    logic [DATA_WIDTH-1:0] skid_data;

    logic                  can_read;
    logic [1:0]            req;
    logic [1:0]            gnt;
    logic [DATA_WIDTH-1:0] sel_data;

    // A parked word blocks new reads, so pending and skid_valid never overlap.
    assign can_read = ~out_full_i & ~skid_valid & ~reset;
    assign req      = {~b_empty_i, ~a_empty_i} & {2{can_read}};

    rr_arb2 u_arb (
        .req        (req),
        .last_grant (last_grant == SRC_B),
        .gnt        (gnt)
    );

    assign a_rden_o = gnt[0];
    assign b_rden_o = gnt[1];

    assign sel_data   = skid_valid ? skid_data
                      : (pend_src == SRC_B) ? b_data_i : a_data_i;
    assign out_data_o = sel_data;
    // Reset also suppresses the write of a word still in flight.
    assign out_wren_o = (skid_valid | pending) & ~out_full_i & ~reset;

    always_ff @(posedge clk) begin
        if (reset) begin
            pending    <= 1'b0;
            pend_src   <= SRC_A;
            last_grant <= SRC_B;
            skid_valid <= 1'b0;
        end else begin
            pending <= |gnt;
            if (|gnt) begin
                pend_src   <= gnt_to_src(gnt);
                last_grant <= gnt_to_src(gnt);
            end
            if (pending & out_full_i) begin
                skid_valid <= 1'b1;
                skid_data  <= sel_data;
            end else if (skid_valid & ~out_full_i) begin
                skid_valid <= 1'b0;
            end
        end
    end

endmodule

// File: doc/fifo_merge_node.md
# fifo_merge_node

Two-to-one merge stage of the FIFO tree. It drains two upstream FIFO_Buffer instances through their read ports and writes the merged word stream into one downstream FIFO_Buffer's write port. Arbitration is round-robin. The node accounts for the buffer's one-cycle read latency with a single-entry skid register, so no word is lost or duplicated when the downstream buffer fills. Nodes cascade to form the tree.

## Interface
- DATA_WIDTH, 36, width of every data word (clause/literal payload)
- clk  input  1  system clock; all state updates on posedge
- reset  input  1  synchronous, active-high; clears all node state
- a_data_i  input  DATA_WIDTH  upstream FIFO A data_o; valid the cycle after a_rden_o
- a_empty_i  input  1  upstream FIFO A empty_o
- a_rden_o  output  1  upstream FIFO A rden_i
- b_data_i  input  DATA_WIDTH  upstream FIFO B data_o
- b_empty_i  input  1  upstream FIFO B empty_o
- b_rden_o  output  1  upstream FIFO B rden_i
- out_data_o  output  DATA_WIDTH  downstream FIFO data_i
- out_wren_o  output  1  downstream FIFO wren_i
- out_full_i  input  1  downstream FIFO full_o

## Operation
- State:
  - pending (1b): a read was issued last cycle.
  - pend_src (1b): source of that read (0=A, 1=B).
  - skid_valid (1b) and skid_data (DATA_WIDTH): one parked word.
  - last_grant (1b): source of the most recent grant.
- Read issue (combinational): can_read = ~out_full_i & ~skid_valid & ~reset.
  - If only A is non-empty, grant A; if only B is non-empty, grant B.
  - If both are non-empty, grant the source ≠ last_grant.
  - At most one of a_rden_o/b_rden_o is high in any cycle.
  - A read is never issued to an empty source.
- On grant: pending←1, pend_src←granted source, last_grant←granted source. Otherwise pending←0.
- Output word selection: skid_valid ? skid_data : (pend_src ? b_data_i : a_data_i).
- out_wren_o = (skid_valid | pending) & ~out_full_i.
- Skid load: if pending & out_full_i, then skid_valid←1 and skid_data←the selected input word.
- Skid drain: if skid_valid & ~out_full_i, skid_valid←0.
- Invariant: skid_valid and pending are never both 1. Reads are blocked while skid_valid, and a skid load only happens in a cycle with no read issued.
- Reset:
  - Clears pending and skid_valid; last_grant←1, so A wins the first tie. skid_data is don't-care.
  - A word in flight at reset is dropped. The whole tree is reset together, so this is acceptable.

## Timing
- Reset values: a_rden_o=0, b_rden_o=0, out_wren_o=0. out_data_o is a_data_i (mux default, don't-care).
- Latency: a read issued in cycle t is written downstream in cycle t+1 if out_full_i=0 at t+1. Otherwise it is written in the first cycle after t+1 with out_full_i=0 (from the skid).
- Throughput: one word per cycle while the downstream is not full and at least one upstream is non-empty.
- Full boundary: out_full_i is sampled in the issue cycle, so no read is issued while full. If the buffer becomes full with a read in flight, that word goes to the skid.
- Empty boundary: a_empty_i and b_empty_i are used in the same cycle. The upstream FIFO's empty must already reflect its own prior read, which is the FIFO_Buffer contract.
- Simultaneous events: an upstream going empty in the same cycle the skid drains has no effect on the skid. Reset wins over every other event.

## Structure
- Shared package sat_fifo_pkg holds DATA_WIDTH (default 36) and the buffer depth constants shared with FIFO_Buffer.
- One natural sub-module: rr_arb2, a 2-input round-robin arbiter (req[1:0], last_grant → gnt[1:0]). It is reused by wider tree nodes.
- Tree-level wiring is out of scope; a separate top instantiates the nodes.

## Test plan
- Reset held 2 cycles with both upstreams non-empty → a_rden_o=b_rden_o=out_wren_o=0 throughout. The first read after reset goes to A.
- A holds 0x1_0000_0001..0x1_0000_0003, B is empty, downstream is free → 3 consecutive A reads. Downstream receives the 3 words in order, one per cycle, starting 1 cycle after the first read.
- A and B each hold 4 words → reads alternate A,B,A,B… Output order is A0,B0,A1,B1,…, 8 writes in 8 consecutive cycles.
- Downstream becomes full in the cycle after read of word 0x5 → the word parks in the skid, and no rden for the whole full period. The word is written on the first cycle with full=0, then reads resume the next cycle.
- out_full_i held 1 for 10 cycles with both upstreams non-empty → zero rden, zero wren, no words lost. After release, all words are delivered exactly once.
- Reset asserted in the cycle after a read of 0xABC → no write of 0xABC. All outputs are 0 the cycle after reset.
